// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_lsu
// Purpose  : Memory-access pipeline stage. Runs req/gnt/rvalid data-bus
//            transactions, aligns/extends loads, encodes stores, flags
//            misaligned accesses and registers writeback for MEM/WB.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lsu #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int RADDR_WIDTH = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                   reg_we_i,
    input  logic [DATA_WIDTH-1:0]  reg_wdata_i,
    input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
    input  logic [DATA_WIDTH-1:0]  mem_data_i,
    input  logic [3:0]             mem_op_i,
    input  logic                   mem_we_i,
    input  logic                   flush_i,
    output logic                   bus_req_o,
    output logic                   bus_we_o,
    output logic [ADDR_WIDTH-1:0]  bus_addr_o,
    output logic [DATA_WIDTH-1:0]  bus_wdata_o,
    output logic [3:0]             bus_be_o,
    input  logic                   bus_gnt_i,
    input  logic                   bus_rvalid_i,
    input  logic [DATA_WIDTH-1:0]  bus_rdata_i,
    output logic                   stall_o,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic                   reg_we_o,
    output logic [DATA_WIDTH-1:0]  reg_wdata_o,
    output logic [1:0]             exc_o,
    output logic [ADDR_WIDTH-1:0]  exc_addr_o
);

    localparam logic [3:0] c_OP_LB  = 4'd1;
    localparam logic [3:0] c_OP_LH  = 4'd2;
    localparam logic [3:0] c_OP_LW  = 4'd3;
    localparam logic [3:0] c_OP_LBU = 4'd4;
    localparam logic [3:0] c_OP_LHU = 4'd5;
    localparam logic [3:0] c_OP_SB  = 4'd6;
    localparam logic [3:0] c_OP_SH  = 4'd7;
    localparam logic [3:0] c_OP_SW  = 4'd8;

    localparam logic [1:0] c_SZ_BYTE = 2'd0;
    localparam logic [1:0] c_SZ_HALF = 2'd1;
    localparam logic [1:0] c_SZ_WORD = 2'd2;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;

    localparam logic [1:0] c_EXC_NONE = 2'b00;
    localparam logic [1:0] c_EXC_LOAD = 2'b01;
    localparam logic [1:0] c_EXC_STOR = 2'b10;

    logic [1:0]            r_state;
    logic [3:0]            r_op;
    logic [1:0]            r_lane;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [3:0]            r_be;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [RADDR_WIDTH-1:0] r_waddr;
    logic                  r_suppress;

    logic                  w_is_load;
    logic                  w_is_store;
    logic                  w_is_mem;
    logic [1:0]            w_size;
    logic                  w_misaligned;
    logic                  w_start;
    logic                  w_in_req;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic                  w_unused;

    // The op code alone decides load/store; the separate store flag is redundant.
    assign w_unused = mem_we_i;

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_size     = c_SZ_BYTE;
        case (mem_op_i)
            c_OP_LB, c_OP_LBU: begin w_is_load  = 1'b1; w_size = c_SZ_BYTE; end
            c_OP_LH, c_OP_LHU: begin w_is_load  = 1'b1; w_size = c_SZ_HALF; end
            c_OP_LW:           begin w_is_load  = 1'b1; w_size = c_SZ_WORD; end
            c_OP_SB:           begin w_is_store = 1'b1; w_size = c_SZ_BYTE; end
            c_OP_SH:           begin w_is_store = 1'b1; w_size = c_SZ_HALF; end
            c_OP_SW:           begin w_is_store = 1'b1; w_size = c_SZ_WORD; end
            default: ;
        endcase
    end

    assign w_is_mem     = w_is_load | w_is_store;
    assign w_misaligned = ((w_size == c_SZ_HALF) & mem_addr_i[0]) |
                          ((w_size == c_SZ_WORD) & (|mem_addr_i[1:0]));
    assign w_start      = (r_state == c_IDLE) & w_is_mem & ~w_misaligned & ~flush_i;

    // Store data is replicated across lanes so the byte enables alone select the target.
    always_comb begin
        w_be    = 4'b0001 << mem_addr_i[1:0];
        w_wdata = {4{mem_data_i[7:0]}};
        case (w_size)
            c_SZ_HALF: begin
                w_be    = 4'b0011 << mem_addr_i[1:0];
                w_wdata = {2{mem_data_i[15:0]}};
            end
            c_SZ_WORD: begin
                w_be    = 4'b1111;
                w_wdata = mem_data_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = bus_rdata_i[7:0];
        case (r_lane)
            2'd1:    w_byte = bus_rdata_i[15:8];
            2'd2:    w_byte = bus_rdata_i[23:16];
            2'd3:    w_byte = bus_rdata_i[31:24];
            default: w_byte = bus_rdata_i[7:0];
        endcase
        w_half      = r_lane[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        w_load_data = bus_rdata_i;
        case (r_op)
            c_OP_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_OP_LBU: w_load_data = {24'd0, w_byte};
            c_OP_LH:  w_load_data = {{16{w_half[15]}}, w_half};
            c_OP_LHU: w_load_data = {16'd0, w_half};
            default:  w_load_data = bus_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= c_IDLE;
            r_op       <= 4'd0;
            r_lane     <= 2'd0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_be       <= 4'd0;
            r_wdata    <= '0;
            r_waddr    <= '0;
            r_suppress <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_suppress <= 1'b0;
                    if (w_start) begin
                        r_state <= c_REQ;
                        r_op    <= mem_op_i;
                        r_lane  <= mem_addr_i[1:0];
                        r_addr  <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        r_we    <= w_is_store;
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        r_waddr <= reg_waddr_i;
                    end
                end
                c_REQ: begin
                    // Once granted the access cannot be recalled, so a flush only mutes writeback.
                    if (bus_gnt_i) begin
                        r_state    <= c_WAIT;
                        r_suppress <= flush_i;
                    end else if (flush_i) begin
                        r_state <= c_IDLE;
                    end
                end
                c_WAIT: begin
                    if (bus_rvalid_i) begin
                        r_state    <= c_IDLE;
                        r_suppress <= 1'b0;
                    end else if (flush_i) begin
                        r_suppress <= 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reg_waddr_o <= '0;
            reg_we_o    <= 1'b0;
            reg_wdata_o <= '0;
            exc_o       <= c_EXC_NONE;
            exc_addr_o  <= '0;
        end else begin
            reg_we_o <= 1'b0;
            exc_o    <= c_EXC_NONE;
            case (r_state)
                c_IDLE: begin
                    reg_waddr_o <= reg_waddr_i;
                    reg_wdata_o <= reg_wdata_i;
                    if (!flush_i) begin
                        if (!w_is_mem) begin
                            reg_we_o <= reg_we_i;
                        end else if (w_misaligned) begin
                            exc_o      <= w_is_store ? c_EXC_STOR : c_EXC_LOAD;
                            exc_addr_o <= mem_addr_i;
                        end
                    end
                end
                c_WAIT: begin
                    if (bus_rvalid_i) begin
                        reg_waddr_o <= r_waddr;
                        reg_wdata_o <= w_load_data;
                        reg_we_o    <= ~r_we & ~(r_suppress | flush_i);
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_in_req    = (r_state == c_REQ);
    assign bus_req_o   = w_in_req;
    assign bus_we_o    = w_in_req & r_we;
    assign bus_addr_o  = w_in_req ? r_addr  : '0;
    assign bus_wdata_o = w_in_req ? r_wdata : '0;
    assign bus_be_o    = w_in_req ? r_be    : 4'd0;

    assign stall_o = ~rst_i & (w_start | w_in_req | ((r_state == c_WAIT) & ~bus_rvalid_i));

endmodule
`default_nettype wire

// File: doc/mem_lsu.md
# mem_lsu

Memory-access stage of the core pipeline, directly downstream of the EX/MEM register. Takes the registered register-writeback and load/store fields and runs a req/gnt/rvalid transaction on the data bus for loads and stores. Aligns and extends load data, generates byte enables for stores, and raises misalignment exceptions. Produces registered writeback fields for MEM/WB and a stall that holds upstream stages while a transaction is outstanding.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (fixed 32 for lane logic)
- RADDR_WIDTH, 5, register-file address width
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- reg_waddr_i / reg_we_i / reg_wdata_i  in  RADDR_WIDTH/1/DATA_WIDTH  writeback fields from EX/MEM
- mem_addr_i  in  ADDR_WIDTH  byte address of access
- mem_data_i  in  DATA_WIDTH  store data (low bits used for SB/SH)
- mem_op_i  in  4  0 NOP, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9-15 treated as NOP
- mem_we_i  in  1  store flag; informational only, mem_op_i governs
- flush_i  in  1  interrupt flush
- bus_req_o  out  1  request
- bus_we_o  out  1  1 = write
- bus_addr_o  out  ADDR_WIDTH  word address {addr[31:2],2'b00}
- bus_wdata_o  out  DATA_WIDTH  lane-replicated store data
- bus_be_o  out  4  byte enables
- bus_gnt_i  in  1  request accepted
- bus_rvalid_i  in  1  response valid (loads and stores)
- bus_rdata_i  in  DATA_WIDTH  read data
- stall_o  out  1  hold upstream stages (combinational)
- reg_waddr_o / reg_we_o / reg_wdata_o  out  RADDR_WIDTH/1/DATA_WIDTH  registered writeback to MEM/WB
- exc_o  out  2  registered: 00 none, 01 load misaligned, 10 store misaligned
- exc_addr_o  out  ADDR_WIDTH  registered faulting address

## Operation
- A memory op is any load or store code. Misaligned means: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
- FSM states: IDLE, REQ, WAIT.
- IDLE, non-memory op (not flushed): next edge registers reg_* through; exc_o=00.
- IDLE, misaligned op: no bus access, no stall. Next edge sets exc_o and exc_addr_o=mem_addr_i, reg_we_o=0.
- IDLE, aligned memory op: stall_o=1. Capture op, addr, data and reg_waddr_i into internal registers, then go to REQ. Outputs become a bubble (reg_we_o=0).
- REQ: bus_req_o=1; bus_* are driven only from captured registers; stall_o=1.
  - bus_gnt_i=1 → WAIT.
  - flush_i=1 with bus_gnt_i=0 → abort to IDLE, no bus effect.
  - flush_i=1 with bus_gnt_i=1 → WAIT, with writeback suppression latched.
- WAIT: bus_req_o=0; stall_o=!bus_rvalid_i.
  - On bus_rvalid_i → IDLE. Next edge writes reg_we_o=1 for loads (0 for stores or when suppressed), with reg_wdata_o set to the extracted load data.
  - flush_i in WAIT sets suppression; the transaction always completes.
- Load extraction, lane = addr[1:0]:
  - LB/LBU: byte at lane, sign- or zero-extended.
  - LH/LHU: halfword at addr[1], sign- or zero-extended.
  - LW: full word.
- Store encoding:
  - SB: wdata={4{d[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{d[15:0]}}, be=4'b0011<<addr[1:0].
  - SW: wdata=d, be=4'b1111.
- bus_gnt_i outside REQ and bus_rvalid_i outside WAIT are ignored.
- flush_i in IDLE: next edge outputs a bubble (reg_we_o=0, exc_o=00) and no access starts.

## Timing
- Reset (async): state=IDLE; bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_wdata_o=0, bus_be_o=0; reg_waddr_o=0, reg_we_o=0, reg_wdata_o=0; exc_o=00, exc_addr_o=0; suppression cleared.
- Reset mid-transaction drops the request immediately; the bus owner must tolerate this.
- Non-memory op: 1-cycle latency, no stall.
- Memory op, gnt in first REQ cycle, rvalid one cycle later:
  - Cycle 0: IDLE.
  - Cycle 1: REQ with gnt.
  - Cycle 2: WAIT with rvalid.
  - Writeback visible in cycle 3.
  - stall_o=1 in cycles 0-1 and 0 in cycle 2, so upstream advances on the rvalid edge.
- Each gnt-wait cycle and each rvalid-wait cycle adds one cycle of latency and stall.
- At most one outstanding transaction.
- Upstream presents its next op in the cycle after stall_o falls.

## Test plan
- ALU passthrough: waddr=5, we=1, wdata=0x1234, op=NOP → next cycle reg_waddr_o=5, reg_we_o=1, reg_wdata_o=0x1234; stall_o never 1.
- LB sign-extend: addr=0x103, rdata=0x80FF_FF7F, gnt immediate, rvalid after 1 cycle → bus_addr_o=0x100; reg_wdata_o=0xFFFF_FF80; stall_o high for 2 cycles.
- SH: addr=0x202, data=0xAAAA_BEEF → bus_we_o=1, bus_be_o=4'b1100, bus_wdata_o=0xBEEF_BEEF; reg_we_o=0 after rvalid.
- Delayed handshake: gnt withheld 3 cycles, rvalid 2 cycles after gnt, LW rdata=0xDEADBEEF → bus_req_o held 4 cycles with stable addr; writeback 0xDEADBEEF; stall released exactly in the rvalid cycle.
- Misaligned LW: addr=0x41 → no bus_req_o; next cycle exc_o=01, exc_addr_o=0x41, reg_we_o=0; no stall.
- Flush cases:
  - flush_i in REQ before gnt → req drops, IDLE, no writeback.
  - flush_i in WAIT → transaction completes on rvalid, reg_we_o stays 0.
  - rst_i asserted in WAIT → all outputs zero immediately.
